uart_resp_packer: RTL

//  Transmit-side counterpart of the UART register-write path. On a host request it snapshots a

---
 rtl/uart_resp_packer_pkg.sv | 18 +
 rtl/uart_resp_packer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/uart_resp_packer_pkg.sv
// rtl/uart_resp_packer_pkg.sv - shared UART response framing constants and FSM state encoding
package uart_resp_packer_pkg;

  localparam logic [7:0] HEAD0     = 8'h55;
  localparam logic [7:0] HEAD1     = 8'hAA;
  localparam logic [7:0] FUNC_HS   = 8'h01;
  localparam logic [7:0] FUNC_LS   = 8'h02;
  localparam int         FRAME_LEN = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } state_t;

endpackage

// File: rtl/uart_resp_packer.sv
// rtl/uart_resp_packer.sv - snapshots a function code and payload, streams a checksummed response frame to uart_tx
module uart_resp_packer
  import uart_resp_packer_pkg::*;
#(
  parameter int _PAYLOAD_BYTES = 10,
  parameter int _ACK_TIMEOUT   = 16
) (
  input  logic                        clk_50M,
  input  logic                        rst_n,
  input  logic                        req,
  input  logic [7:0]                  req_func,
  input  logic [8*_PAYLOAD_BYTES-1:0] req_payload,
  output logic                        req_ready,
  output logic [7:0]                  tx_data,
  output logic                        tx_start,
  input  logic                        tx_busy,
  output logic                        frame_busy,
  output logic                        frame_done,
  output logic                        err_timeout,
  output logic                        req_drop
);

  localparam int FRAME_BYTES = _PAYLOAD_BYTES + 4;
  localparam int IDX_W       = $clog2(FRAME_BYTES);
  localparam int TO_W        = $clog2(_ACK_TIMEOUT + 1);

  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_FUNC = IDX_W'(2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(_ACK_TIMEOUT - 1);

  state_t                      state, next_state;
  logic [IDX_W-1:0]            byte_idx;
  logic [TO_W-1:0]             to_cnt;
  logic [7:0]                  chk_acc;
  logic [7:0]                  snap_func;
  logic [8*_PAYLOAD_BYTES-1:0] snap_payload;
  logic [8*_PAYLOAD_BYTES-1:0] pay_shift;
  logic [IDX_W-1:0]            pay_off;
  logic [7:0]                  cur_byte;
  logic                        accept, frame_end, ack_timeout;

  // D1 sits in the top byte of the snapshot, so the shift distance shrinks as byte_idx grows.
  always_comb begin
    pay_off   = LAST_IDX - IDX_ONE - byte_idx;
    pay_shift = snap_payload >> {pay_off, 3'b000};
    cur_byte  = pay_shift[7:0];
    if (byte_idx == '0)            cur_byte = HEAD0;
    else if (byte_idx == IDX_ONE)  cur_byte = HEAD1;
    else if (byte_idx == IDX_FUNC) cur_byte = snap_func;
    else if (byte_idx == LAST_IDX) cur_byte = chk_acc;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    frame_end   = 1'b0;
    ack_timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req && req_ready) begin
          accept     = 1'b1;
          next_state = ST_LOAD;
        end
      end
      ST_LOAD:  next_state = ST_START;
      ST_START: next_state = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (tx_busy) begin
          next_state = ST_WAIT_DONE;
        end else if (to_cnt == TO_LAST) begin
          ack_timeout = 1'b1;
          next_state  = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (byte_idx == LAST_IDX) begin
            frame_end  = 1'b1;
            next_state = ST_IDLE;
          end else begin
            next_state = ST_LOAD;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // req_ready is held low for the frame_done / err_timeout cycle so a request there is dropped.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx     <= '0;
      to_cnt       <= '0;
      chk_acc      <= 8'h00;
      snap_func    <= 8'h00;
      snap_payload <= '0;
      tx_data      <= 8'h00;
      tx_start     <= 1'b0;
      req_ready    <= 1'b1;
      frame_busy   <= 1'b0;
      frame_done   <= 1'b0;
      err_timeout  <= 1'b0;
      req_drop     <= 1'b0;
    end else begin
      tx_start    <= (next_state == ST_START);
      frame_busy  <= (next_state != ST_IDLE);
      req_ready   <= (next_state == ST_IDLE) && !frame_end && !ack_timeout;
      frame_done  <= frame_end;
      err_timeout <= ack_timeout;
      req_drop    <= req && !req_ready;

      if (accept) begin
        snap_func    <= req_func;
        snap_payload <= req_payload;
        chk_acc      <= req_func;
        byte_idx     <= '0;
      end

      if (state == ST_LOAD) begin
        tx_data <= cur_byte;
        if (byte_idx > IDX_FUNC && byte_idx < LAST_IDX) chk_acc <= chk_acc + cur_byte;
      end

      if (state == ST_START)         to_cnt <= '0;
      else if (state == ST_WAIT_ACK) to_cnt <= to_cnt + TO_W'(1);

      if (state == ST_WAIT_DONE && !tx_busy && byte_idx != LAST_IDX) byte_idx <= byte_idx + IDX_ONE;
    end
  end

endmodule
